// File: rtl/servo_pkg.sv
// servo_pkg: shared definitions for the servo PWM path and the command block.
//   - angle codes driven by the switch/fire command logic
//   - default board timing constants (25 MHz clock, 20 ms frame, 1.0-2.0 ms pulse)
//   - width_t: 12-bit pulse width in microseconds
//   - map_angle(): angle code to target pulse width
package servo_pkg;

    typedef enum logic [3:0] {
        ANG_STOP = 4'd0,
        ANG_NEG  = 4'd1,
        ANG_POS  = 4'd2,
        ANG_HOLD = 4'd5
    } angle_e;

    localparam int unsigned DEF_CLKS_PER_US = 25;
    localparam int unsigned DEF_FRAME_US    = 20000;
    localparam int unsigned DEF_MIN_US      = 1000;
    localparam int unsigned DEF_MID_US      = 1500;
    localparam int unsigned DEF_MAX_US      = 2000;
    localparam int unsigned DEF_SLEW_US     = 50;

    localparam int unsigned WIDTH_W = 12;
    typedef logic [WIDTH_W-1:0] width_t;

    // Undefined codes park the servo at centre, same as STOP and HOLD.
    function automatic width_t map_angle(input logic [3:0] code,
                                         input width_t     lo,
                                         input width_t     mid,
                                         input width_t     hi);
        width_t w;
        case (code)
            ANG_NEG: w = lo;
            ANG_POS: w = hi;
            default: w = mid;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// us_tick_gen: microsecond prescaler. Counts 0..CLKS_PER_US-1 and asserts
// tick_o for the one cycle in which the count sits at its last value, so the
// consumer advances on the same edge the prescaler wraps.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset (count returns to 0)
//   tick_o  one-cycle strobe once per microsecond
module us_tick_gen #(
    parameter int unsigned CLKS_PER_US = 25
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int unsigned PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLKS_PER_US - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + PW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: hobby-servo PWM frame generator with per-frame slew limiting.
//   i_Clk          system clock
//   i_Rst_L        asynchronous active-low reset
//   i_Enable       pulse enable, sampled at frame boundaries
//   i_Angle        4-bit angle code (see servo_pkg)
//   o_Pwm          servo control pulse, high for width*CLKS_PER_US clocks
//   o_Frame_Start  one-cycle strobe at the start of each frame
//   o_Width_Us     currently applied pulse width in us
//   o_Settled      width has reached the target
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int unsigned CLKS_PER_US = DEF_CLKS_PER_US,
    parameter int unsigned FRAME_US    = DEF_FRAME_US,
    parameter int unsigned MIN_US      = DEF_MIN_US,
    parameter int unsigned MID_US      = DEF_MID_US,
    parameter int unsigned MAX_US      = DEF_MAX_US,
    parameter int unsigned SLEW_US     = DEF_SLEW_US
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    input  logic         i_Enable,
    input  logic [3:0]   i_Angle,
    output logic         o_Pwm,
    output logic         o_Frame_Start,
    output logic [11:0]  o_Width_Us,
    output logic         o_Settled
);

    if (!(MIN_US <= MID_US && MID_US <= MAX_US && MAX_US < FRAME_US &&
          MAX_US < 4096 && SLEW_US >= 1 && FRAME_US <= 32768)) begin : g_param_err
        $error("servo_pwm_gen: illegal timing parameters");
    end

    localparam logic [14:0] FRAME_LAST = 15'(FRAME_US - 1);
    localparam width_t W_MIN  = width_t'(MIN_US);
    localparam width_t W_MID  = width_t'(MID_US);
    localparam width_t W_MAX  = width_t'(MAX_US);
    localparam width_t W_SLEW = width_t'(SLEW_US);

    logic        tick;
    logic        boundary;
    logic [14:0] frame_q, frame_d;
    width_t      target_q, target_d;
    width_t      width_q, width_d;
    logic        active_q, active_d;
    logic        pwm_q, pwm_d;
    logic        fs_q, fs_d;
    logic        settled_q, settled_d;

    us_tick_gen #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
        .clk_i  (i_Clk),
        .rst_ni (i_Rst_L),
        .tick_o (tick)
    );

    // Step toward target by at most W_SLEW; differences are taken in the
    // direction that cannot underflow, so no wrap at 12 bits.
    function automatic width_t slew_step(input width_t cur, input width_t tgt);
        width_t diff;
        width_t nxt;
        nxt = cur;
        if (tgt > cur) begin
            diff = tgt - cur;
            nxt  = cur + ((diff > W_SLEW) ? W_SLEW : diff);
        end else if (tgt < cur) begin
            diff = cur - tgt;
            nxt  = cur - ((diff > W_SLEW) ? W_SLEW : diff);
        end
        return nxt;
    endfunction

    assign boundary = tick && (frame_q == FRAME_LAST);

    always_comb begin
        frame_d   = frame_q;
        target_d  = target_q;
        active_d  = active_q;
        width_d   = width_q;
        settled_d = settled_q;
        fs_d      = 1'b0;
        if (tick) frame_d = boundary ? '0 : frame_q + 15'd1;
        if (boundary) begin
            target_d  = map_angle(i_Angle, W_MIN, W_MID, W_MAX);
            active_d  = i_Enable;
            width_d   = slew_step(width_q, target_d);
            settled_d = (width_d == target_d);
            fs_d      = 1'b1;
        end
        // Decoded from next-state values so the pulse rises together with
        // o_Frame_Start and lasts exactly width_d microseconds.
        pwm_d = active_d && ({3'b000, width_d} > frame_d);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            frame_q   <= '0;
            target_q  <= W_MID;
            width_q   <= W_MID;
            active_q  <= 1'b0;
            pwm_q     <= 1'b0;
            fs_q      <= 1'b0;
            settled_q <= 1'b1;
        end else begin
            frame_q   <= frame_d;
            target_q  <= target_d;
            width_q   <= width_d;
            active_q  <= active_d;
            pwm_q     <= pwm_d;
            fs_q      <= fs_d;
            settled_q <= settled_d;
        end
    end

    assign o_Pwm         = pwm_q;
    assign o_Frame_Start = fs_q;
    assign o_Width_Us    = width_q;
    assign o_Settled     = settled_q;

endmodule
